// File: rtl/packet_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : packet_deserializer                                        |
// | Description : Receive-side packet framer. Hunts a recovered bit stream   |
// |               for the sync byte, assembles a PACKET_SIZE-bit packet      |
// |               MSB-first, presents it in parallel and drains it as a      |
// |               valid/ready byte stream (most significant byte first).     |
// | Ports       : clock        - rising-edge clock                           |
// |               reset        - synchronous, active-high reset              |
// |               bit_in       - recovered data bit (qualified by bit_valid) |
// |               bit_valid    - one-cycle strobe per recovered bit          |
// |               packet_out   - last complete packet, MSB = first bit       |
// |               packet_valid - one-cycle pulse when packet_out updates     |
// |               byte_out     - current byte of the drain stream            |
// |               byte_valid   - byte_out is valid (high throughout DRAIN)   |
// |               byte_ready   - downstream accepts byte_out                 |
// |               locked       - high while collecting packet bits           |
// |               overrun      - pulse per valid bit dropped during DRAIN    |
// | Build option: PACKET_DESERIALIZER_SYNC_STRIP_EN - when defined the sync   |
// |               byte is kept in packet_out but not drained.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module packet_deserializer #(
  parameter int         PACKET_SIZE = 192,
  parameter logic [7:0] SYNC_WORD   = 8'hFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [PACKET_SIZE-1:0] packet_out,
  output logic                   packet_valid,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   locked,
  output logic                   overrun
);

  localparam int CNT_W     = $clog2(PACKET_SIZE + 1);
  localparam int NUM_BYTES = PACKET_SIZE / 8;
  localparam int PTR_W     = $clog2(NUM_BYTES);

`ifdef PACKET_DESERIALIZER_SYNC_STRIP_EN
  localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] FIRST_PTR = PTR_W'(0);
`endif
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0] SYNC_LEN = CNT_W'(8);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0]             state;
  logic [1:0]             next_state;
  logic [7:0]             hunt_reg;
  logic [PACKET_SIZE-1:0] asm_reg;
  logic [PACKET_SIZE-1:0] asm_next;
  logic [CNT_W-1:0]       bit_count;
  logic [CNT_W-1:0]       wr_idx;
  logic [PTR_W-1:0]       byte_ptr;
  logic [7:0]             sync_cand;
  logic                   sync_hit;
  logic                   last_bit;
  logic                   handshake;
  logic                   last_byte;
  logic [7:0]             byte_lane [NUM_BYTES];

  assign sync_cand = {hunt_reg[6:0], bit_in};
  assign sync_hit  = (state == ST_HUNT) && bit_valid && (sync_cand == SYNC_WORD);
  assign last_bit  = (state == ST_COLLECT) && bit_valid && (bit_count == LAST_BIT);
  assign handshake = (state == ST_DRAIN) && byte_ready;
  assign last_byte = handshake && (byte_ptr == LAST_PTR);

  // Bits are written in place, top-down, so the sync byte loaded at the top
  // never has to move while the rest of the packet fills in below it.
  assign wr_idx = LAST_BIT - bit_count;

  always_comb begin
    asm_next = asm_reg;
    if (state == ST_COLLECT) begin
      asm_next[wr_idx] = bit_in;
    end
  end

  // Byte lanes of the held packet, lane 0 = most significant byte.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lanes
    assign byte_lane[i] = packet_out[PACKET_SIZE-1-8*i -: 8];
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_HUNT:    if (sync_hit)  next_state = ST_COLLECT;
      ST_COLLECT: if (last_bit)  next_state = ST_DRAIN;
      ST_DRAIN:   if (last_byte) next_state = ST_HUNT;
      default:                   next_state = ST_HUNT;
    endcase
  end

  // Output logic: the drain stream is read straight from packet_out so the
  // presented byte cannot change while the downstream stalls.
  always_comb begin
    locked     = (state == ST_COLLECT);
    byte_valid = (state == ST_DRAIN);
    byte_out   = 8'h00;
    if (state == ST_DRAIN) begin
      byte_out = byte_lane[byte_ptr];
    end
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      hunt_reg     <= 8'h00;
      asm_reg      <= '0;
      bit_count    <= '0;
      byte_ptr     <= '0;
      packet_out   <= '0;
      packet_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      packet_valid <= last_bit;
      overrun      <= (state == ST_DRAIN) && bit_valid;
      case (state)
        ST_HUNT: begin
          if (bit_valid) begin
            hunt_reg <= sync_cand;
          end
          if (sync_hit) begin
            asm_reg   <= {sync_cand, {(PACKET_SIZE-8){1'b0}}};
            bit_count <= SYNC_LEN;
          end
        end
        ST_COLLECT: begin
          if (bit_valid) begin
            asm_reg   <= asm_next;
            bit_count <= bit_count + CNT_W'(1);
          end
          if (last_bit) begin
            packet_out <= asm_next;
            byte_ptr   <= FIRST_PTR;
          end
        end
        ST_DRAIN: begin
          if (handshake) begin
            byte_ptr <= byte_ptr + PTR_W'(1);
          end
          // A fresh hunt must see a whole new sync byte after a packet.
          if (last_byte) begin
            hunt_reg <= 8'h00;
          end
        end
        default: begin
          hunt_reg <= 8'h00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_packet_deserializer                                     |
// | Description : Self-checking bench for packet_deserializer. Packets are   |
// |               random (sync byte on top) or the fixed text packet; the    |
// |               expected byte stream is sliced from the packet value.      |
// | Build option: PACKET_DESERIALIZER_SYNC_STRIP_EN selects the expected      |
// |               drain (sync byte stripped or not).                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_packet_deserializer;

  localparam int PS = 192;
  localparam int NB = PS / 8;
`ifdef PACKET_DESERIALIZER_SYNC_STRIP_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_in;
  logic          bit_valid;
  logic [PS-1:0] packet_out;
  logic          packet_valid;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          locked;
  logic          overrun;

  packet_deserializer #(.PACKET_SIZE(PS), .SYNC_WORD(8'hFF)) dut (
    .clock       (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .packet_out  (packet_out),
    .packet_valid(packet_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .locked      (locked),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_edge = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Observation (monitor is the only writer of these)
  logic [7:0] obs_bytes [$];
  int pv_count = 0;
  int pv_cycle = -1;
  int ov_count = 0;
  int lock_cycles = 0;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (byte_valid === 1'b1 && byte_ready === 1'b1) obs_bytes.push_back(byte_out);
      if (packet_valid === 1'b1) begin
        pv_count = pv_count + 1;
        pv_cycle = cycle;
      end
      if (overrun === 1'b1) ov_count = ov_count + 1;
      if (locked === 1'b1) lock_cycles = lock_cycles + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PS-1:0] obs, input logic [PS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sends bits [from, from+n) of pkt, MSB first, one strobe every gap cycles.
  task automatic send_bits(input logic [PS-1:0] pkt, input int from, input int n, input int gap);
    for (int i = from; i < from + n; i++) begin
      bit_in    = pkt[PS-1-i];
      bit_valid = 1'b1;
      tick();
      last_edge = cycle;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      for (int k = 1; k < gap; k++) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [PS-1:0] tmp;
    tmp = '0;
    tmp[PS-1 -: 8] = b;
    send_bits(tmp, 0, 8, 1);
  endtask

  function automatic logic [PS-1:0] rand_pkt();
    logic [PS-1:0] p;
    for (int i = 0; i < PS / 32; i++) p[i*32 +: 32] = $urandom;
    p[PS-1 -: 8] = 8'hFF;
    return p;
  endfunction

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (byte_valid === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk_int(tag, int'(n < 400), 1);
  endtask

  task automatic check_bytes(input logic [PS-1:0] pkt, input int base, input string tag);
    logic [7:0] exp_b;
    chk_int({tag, "_count"}, obs_bytes.size() - base, NB - FIRST);
    for (int j = 0; j < NB - FIRST && base + j < obs_bytes.size(); j++) begin
      exp_b = pkt[PS-1-8*(FIRST+j) -: 8];
      chk({tag, "_byte"}, PS'(obs_bytes[base+j]), PS'(exp_b));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_packet_out"}, packet_out, '0);
    chk({tag, "_packet_valid"}, PS'(packet_valid), '0);
    chk({tag, "_byte_out"}, PS'(byte_out), '0);
    chk({tag, "_byte_valid"}, PS'(byte_valid), '0);
    chk({tag, "_locked"}, PS'(locked), '0);
    chk({tag, "_overrun"}, PS'(overrun), '0);
  endtask

  initial begin
    logic [PS-1:0] pkt;
    logic [7:0]    first_b;
    int            base;
    int            pvb;
    int            ovb;
    int            lkb;
    int            gap;

    reset      = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    byte_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Clean text packet, strobes every cycle, sink always ready
    pkt        = 192'hff5468697320697320612074657374206d65737361676521;
    first_b    = pkt[PS-1-8*FIRST -: 8];
    byte_ready = 1'b1;
    base       = obs_bytes.size();
    pvb        = pv_count;
    send_bits(pkt, 0, 7, 1);
    chk("lock_before_sync", PS'(locked), PS'(1'b0));
    send_bits(pkt, 7, 1, 1);
    chk("lock_after_sync", PS'(locked), PS'(1'b1));
    send_bits(pkt, 8, PS - 8, 1);
    chk("clean_pv_rise", PS'(packet_valid), PS'(1'b1));
    chk("clean_bv_rise", PS'(byte_valid), PS'(1'b1));
    chk("clean_first_byte", PS'(byte_out), PS'(first_b));
    chk("clean_packet", packet_out, pkt);
    chk("clean_unlocked", PS'(locked), PS'(1'b0));
    tick();
    chk("clean_pv_fall", PS'(packet_valid), PS'(1'b0));
    wait_drain("clean_drain_done");
    chk_int("clean_pv_count", pv_count - pvb, 1);
    chk_int("clean_pv_cycle", pv_cycle, last_edge);
    check_bytes(pkt, base, "clean");
    tick();

    // Leading noise before a random packet
    pkt  = rand_pkt();
    lkb  = lock_cycles;
    base = obs_bytes.size();
    send_byte(8'h00);
    send_byte(8'h3C);
    chk_int("noise_lock_cycles", lock_cycles - lkb, 0);
    chk("noise_locked", PS'(locked), PS'(1'b0));
    send_bits(pkt, 0, PS, 1);
    chk("noise_packet", packet_out, pkt);
    wait_drain("noise_drain_done");
    check_bytes(pkt, base, "noise");
    tick();

    // Backpressure: sink stalls for 10 cycles after packet_valid
    pkt        = rand_pkt();
    first_b    = pkt[PS-1-8*FIRST -: 8];
    byte_ready = 1'b0;
    base       = obs_bytes.size();
    send_bits(pkt, 0, PS, 1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_valid", PS'(byte_valid), PS'(1'b1));
      chk("bp_hold_byte", PS'(byte_out), PS'(first_b));
      tick();
    end
    byte_ready = 1'b1;
    wait_drain("bp_drain_done");
    check_bytes(pkt, base, "bp");
    tick();

    // Overrun: bits arriving while the packet is stalled in the drain
    pkt        = rand_pkt();
    byte_ready = 1'b0;
    base       = obs_bytes.size();
    pvb        = pv_count;
    send_bits(pkt, 0, PS, 1);
    ovb = ov_count;
    for (int i = 0; i < 5; i++) begin
      bit_in    = 1'($urandom);
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      chk("ovr_pulse", PS'(overrun), PS'(1'b1));
      tick();
      chk("ovr_gap", PS'(overrun), PS'(1'b0));
    end
    chk_int("ovr_count", ov_count - ovb, 5);
    chk("ovr_packet_kept", packet_out, pkt);
    byte_ready = 1'b1;
    wait_drain("ovr_drain_done");
    chk_int("ovr_pv_count", pv_count - pvb, 1);
    check_bytes(pkt, base, "ovr");
    tick();

    // Reset in the middle of collection, then a full resend
    pkt        = rand_pkt();
    byte_ready = 1'b1;
    send_bits(pkt, 0, 100, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    base  = obs_bytes.size();
    pvb   = pv_count;
    send_bits(pkt, 0, PS, 1);
    chk("midreset_packet", packet_out, pkt);
    wait_drain("midreset_drain_done");
    chk_int("midreset_pv_count", pv_count - pvb, 1);
    check_bytes(pkt, base, "midreset");
    tick();

    // Sparse strobes (one every 4 cycles) and random spacings
    for (int r = 0; r < 4; r++) begin
      pkt  = rand_pkt();
      gap  = (r == 0) ? 4 : int'($urandom_range(1, 3));
      base = obs_bytes.size();
      pvb  = pv_count;
      send_bits(pkt, 0, PS, gap);
      chk_int("sparse_pv_cycle", pv_cycle, last_edge);
      wait_drain("sparse_drain_done");
      chk("sparse_packet", packet_out, pkt);
      chk_int("sparse_pv_count", pv_count - pvb, 1);
      check_bytes(pkt, base, "sparse");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
